// File: rtl/lbp_hist_pkg.sv
// Shared constants, FSM state type and address helpers for the LBP histogram tap.
package lbp_hist_pkg;

    localparam int IMG_W  = 128;
    localparam int BIN_N  = 256;
    localparam int CNT_W  = 15;
    localparam int BIN_W  = 8;
    localparam int ADDR_W = 14;
    localparam int COL_W  = $clog2(IMG_W);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(BIN_N - 1);

    typedef enum logic [1:0] {
        ACC,
        DRAIN,
        DUMP,
        DONE
    } state_e;

    // Write issued by the increment stage; kept one extra cycle for forwarding.
    typedef struct packed {
        logic             vld;
        logic [BIN_W-1:0] bin;
        logic [CNT_W-1:0] cnt;
    } wr_req_t;

    // addr = row*IMG_W + col; true when the pixel lies on the outer ring.
    function automatic logic is_border(input logic [ADDR_W-1:0] addr);
        logic [COL_W-1:0] row;
        logic [COL_W-1:0] col;
        row = addr[2*COL_W-1:COL_W];
        col = addr[COL_W-1:0];
        return (row == '0) || (row == COL_W'(IMG_W - 1)) ||
               (col == '0) || (col == COL_W'(IMG_W - 1));
    endfunction

endpackage

// File: rtl/lbp_hist_ram.sv
// 256 x CNT_W bin store: one write port, one read port with registered 1-cycle read.
module lbp_hist_ram
    import lbp_hist_pkg::*;
(
    input  logic             clk,
    input  logic             rd_en_i,
    input  logic [BIN_W-1:0] rd_addr_i,
    output logic [CNT_W-1:0] rd_data_o,
    input  logic             wr_en_i,
    input  logic [BIN_W-1:0] wr_addr_i,
    input  logic [CNT_W-1:0] wr_data_i
);

    logic [CNT_W-1:0] mem_q [BIN_N];
    logic [CNT_W-1:0] rd_data_q;

    // Read returns the pre-write contents on an address collision.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lbp_hist.sv
// 256-bin histogram tap on the LBP result bus with a valid/ready bin dump.
// Optional border exclusion: define LBP_HIST_BORDER_SKIP_EN.
module lbp_hist
    import lbp_hist_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [BIN_W-1:0]  lbp_data,
    input  logic              finish,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [BIN_W-1:0]  hist_bin,
    output logic [CNT_W-1:0]  hist_count,
    output logic              hist_last,
    output logic              hist_done
);

    state_e           state_q, state_d;
    logic [BIN_N-1:0] touched_q;
    logic             s1_vld_q;
    logic [BIN_W-1:0] s1_bin_q;
    wr_req_t          wr_q, wr_d;
    logic             hv_q, hv_d;
    logic [BIN_W-1:0] hb_q, hb_d;

    logic             pix_hit;
    logic             rd_en;
    logic [BIN_W-1:0] rd_addr;
    logic [CNT_W-1:0] rd_data;
    logic [CNT_W-1:0] base_cnt;

`ifdef LBP_HIST_BORDER_SKIP_EN
    assign pix_hit = (state_q == ACC) && lbp_valid && !is_border(lbp_addr);
`else
    logic addr_unused;
    assign addr_unused = ^lbp_addr;
    assign pix_hit     = (state_q == ACC) && lbp_valid;
`endif

    lbp_hist_ram u_ram (
        .clk       (clk),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_d.vld),
        .wr_addr_i (wr_d.bin),
        .wr_data_i (wr_d.cnt)
    );

    // The previous cycle's write lands too late for this stage's RAM read,
    // so it is forwarded; untouched bins read as zero.
    always_comb begin
        if (wr_q.vld && (wr_q.bin == s1_bin_q)) begin
            base_cnt = wr_q.cnt;
        end else if (touched_q[s1_bin_q]) begin
            base_cnt = rd_data;
        end else begin
            base_cnt = '0;
        end
        wr_d.vld = s1_vld_q;
        wr_d.bin = s1_bin_q;
        wr_d.cnt = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        rd_addr = lbp_data;
        hv_d    = hv_q;
        hb_d    = hb_q;
        case (state_q)
            ACC: begin
                rd_en = pix_hit;
                if (finish) state_d = DRAIN;
            end
            DRAIN: begin
                // Prefetch bin 0 once the last increment has been written.
                if (!s1_vld_q) begin
                    state_d = DUMP;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    hv_d    = 1'b1;
                    hb_d    = '0;
                end
            end
            DUMP: begin
                if (hist_ready) begin
                    if (hb_q == BIN_LAST) begin
                        state_d = DONE;
                        hv_d    = 1'b0;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = hb_q + BIN_W'(1);
                        hb_d    = hb_q + BIN_W'(1);
                    end
                end
            end
            DONE: begin
                hv_d = 1'b0;
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ACC;
            touched_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_bin_q  <= '0;
            wr_q      <= '0;
            hv_q      <= 1'b0;
            hb_q      <= '0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= pix_hit;
            s1_bin_q <= lbp_data;
            wr_q     <= wr_d;
            hv_q     <= hv_d;
            hb_q     <= hb_d;
            if (wr_d.vld) touched_q[wr_d.bin] <= 1'b1;
        end
    end

    // RAM output is only updated by dump reads while in DUMP, so it holds under stall.
    assign hist_valid = hv_q;
    assign hist_bin   = hb_q;
    assign hist_last  = hv_q && (hb_q == BIN_LAST);
    assign hist_count = (hv_q && touched_q[hb_q]) ? rd_data : '0;
    assign hist_done  = (state_q == DONE);

endmodule

// File: tb/tb_lbp_hist.sv
// Self-checking bench for lbp_hist: table-driven frames, corner sequences, random frame.
module tb_lbp_hist;

    localparam int MAXC = 32767;

    logic        clk = 1'b0;
    logic        reset;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        hist_valid;
    logic        hist_ready;
    logic [7:0]  hist_bin;
    logic [14:0] hist_count;
    logic        hist_last;
    logic        hist_done;

    lbp_hist dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .hist_last  (hist_last),
        .hist_done  (hist_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q [256];
    int got_q [256];

    typedef struct {
        int code;
        int reps;
        bit seq_addr;
        int exp;
    } vec_t;

    vec_t tbl [3];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic bit border(input int a);
`ifdef LBP_HIST_BORDER_SKIP_EN
        int row, col;
        row = a / 128;
        col = a % 128;
        return (row == 0) || (row == 127) || (col == 0) || (col == 127);
`else
        return (a < 0);
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) exp_q[i] = 0;
    endtask

    task automatic model_add(input int d, input int a);
        if (!border(a)) exp_q[d] = (exp_q[d] < MAXC) ? exp_q[d] + 1 : MAXC;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        lbp_valid = 1'b0;
        finish    = 1'b0;
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic send_pix(input int d, input int a);
        int dv, av;
        dv = d;
        av = a;
        lbp_valid = 1'b1;
        lbp_data  = dv[7:0];
        lbp_addr  = av[13:0];
        model_add(d, a);
        tick();
        lbp_valid = 1'b0;
    endtask

    task automatic do_finish(input bit with_pix, input int d, input int a);
        int dv, av;
        dv = d;
        av = a;
        finish = 1'b1;
        if (with_pix) begin
            lbp_valid = 1'b1;
            lbp_data  = dv[7:0];
            lbp_addr  = av[13:0];
            model_add(d, a);
        end
        tick();
        finish    = 1'b0;
        lbp_valid = 1'b0;
    endtask

    // Collects the 256-bin dump, comparing every transfer against the model.
    task automatic dump(input string tag, input int stall_bin, input int stall_n, input bit rand_rdy);
        int waited, nxt, budget, stalls, gaps, held;
        waited = 0; nxt = 0; budget = 0; stalls = 0; gaps = 0; held = 0;
        for (int i = 0; i < 256; i++) got_q[i] = -1;
        hist_ready = 1'b1;
        while (!hist_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk($sformatf("%s first_valid_latency_le3", tag), int'(waited <= 3), 1);
        while (nxt < 256 && budget < 3000) begin
            if (rand_rdy) begin
                hist_ready = ($urandom_range(0, 3) != 0);
            end else if (nxt == stall_bin && stalls < stall_n) begin
                hist_ready = 1'b0;
                chk($sformatf("%s stall%0d bin", tag, stalls), int'(hist_bin), stall_bin);
                if (stalls == 0) held = int'(hist_count);
                else chk($sformatf("%s stall%0d count", tag, stalls), int'(hist_count), held);
                stalls++;
            end else begin
                hist_ready = 1'b1;
            end
            if (!hist_valid) begin
                gaps++;
            end else if (hist_ready) begin
                chk($sformatf("%s xfer%0d bin", tag, nxt), int'(hist_bin), nxt);
                chk($sformatf("%s bin%0d count", tag, nxt), int'(hist_count), exp_q[nxt]);
                chk($sformatf("%s bin%0d last", tag, nxt), int'(hist_last), int'(nxt == 255));
                got_q[nxt] = int'(hist_count);
                nxt++;
            end
            tick();
            budget++;
        end
        hist_ready = 1'b1;
        chk($sformatf("%s transfers", tag), nxt, 256);
        if (!rand_rdy) chk($sformatf("%s valid_gaps", tag), gaps, 0);
        chk($sformatf("%s done_after_last", tag), int'(hist_done), 1);
        chk($sformatf("%s valid_after_last", tag), int'(hist_valid), 0);
        repeat (4) tick();
        chk($sformatf("%s done_sticky", tag), int'(hist_done), 1);
        chk($sformatf("%s valid_in_done", tag), int'(hist_valid), 0);
    endtask

    initial begin
        int b2b [7];
        reset      = 1'b1;
        lbp_valid  = 1'b0;
        lbp_addr   = '0;
        lbp_data   = '0;
        finish     = 1'b0;
        hist_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_clear();

        chk("reset hist_valid", int'(hist_valid), 0);
        chk("reset hist_bin",   int'(hist_bin),   0);
        chk("reset hist_count", int'(hist_count), 0);
        chk("reset hist_last",  int'(hist_last),  0);
        chk("reset hist_done",  int'(hist_done),  0);

`ifdef LBP_HIST_BORDER_SKIP_EN
        tbl[0] = '{0, 16384, 1'b1, 15876};
`else
        tbl[0] = '{0, 16384, 1'b1, 16384};
`endif
        tbl[1] = '{1, 40000, 1'b1, MAXC};
        tbl[2] = '{8'hC3, 5, 1'b0, 5};

        for (int v = 0; v < 3; v++) begin
            do_reset();
            for (int i = 0; i < tbl[v].reps; i++)
                send_pix(tbl[v].code, tbl[v].seq_addr ? (i % 16384) : (129 + i));
            do_finish(1'b0, 0, 0);
            dump($sformatf("tbl%0d", v), -1, 0, 1'b0);
            chk($sformatf("tbl%0d code_bin", v), got_q[tbl[v].code], tbl[v].exp);
        end

        // Back-to-back same-bin hits, plus a 3-cycle stall on bin 10.
        b2b = '{8'hAA, 8'hAA, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'h55};
        do_reset();
        for (int i = 0; i < 7; i++) send_pix(b2b[i], 129 + i);
        do_finish(1'b0, 0, 0);
        dump("b2b", 10, 3, 1'b0);
        chk("b2b binAA", got_q[8'hAA], 4);
        chk("b2b bin55", got_q[8'h55], 3);

        // Reset mid-frame discards earlier pixels.
        do_reset();
        for (int i = 0; i < 100; i++) send_pix(8'h11, 129 + i);
        do_reset();
        for (int i = 0; i < 10; i++) send_pix(8'h3C, 129 + i);
        do_finish(1'b0, 0, 0);
        dump("midrst", -1, 0, 1'b0);
        chk("midrst bin3C", got_q[8'h3C], 10);
        chk("midrst bin11", got_q[8'h11], 0);

        // Pixel coincident with finish counts; pulses after finish do not.
        do_reset();
        for (int i = 0; i < 20; i++) send_pix($urandom_range(8, 255), 129 + i);
        do_finish(1'b1, 7, 300);
        lbp_valid = 1'b1;
        lbp_data  = 8'h07;
        lbp_addr  = 14'd301;
        dump("fin", -1, 0, 1'b0);
        lbp_valid = 1'b0;
        chk("fin bin07", got_q[7], 1);
        do_reset();
        chk("fin done_cleared_by_reset", int'(hist_done), 0);

        // Random frame with collisions and a random-ready sink.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) != 0)
                send_pix($urandom_range(0, 1) != 0 ? $urandom_range(0, 3) : $urandom_range(0, 255),
                         $urandom_range(0, 16383));
            else
                tick();
        end
        do_finish(1'b1, $urandom_range(0, 255), $urandom_range(0, 16383));
        dump("rand", -1, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
